// File: rtl/button_debounce_fsm.sv
// button_debounce_fsm: synchronises a bouncing button and qualifies each level change over timer ticks
module button_debounce_fsm #(
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS = 50,
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic tick,
  output logic tick_en,
  output logic db_level,
  output logic db_rise,
  output logic db_fall,
  output logic db_hold
);
  localparam int DW = $clog2(STABLE_TICKS + 1);
  localparam int HW = HOLD_TICKS > 0 ? $clog2(HOLD_TICKS + 1) : 1;
  typedef enum logic [1:0] {S_LOW, S_WAIT_H, S_HIGH, S_WAIT_L} state_t;
  state_t state;
  logic [1:0] sync;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic hold_done, btn_s, deb_last, hold_last;
  assign btn_s = sync[1] ^ BTN_ACTIVE_LOW;
  assign deb_last = deb_cnt == DW'(STABLE_TICKS - 1);
  assign hold_last = hold_cnt == HW'(HOLD_TICKS - 1);
  // a btn_s reversal is tested before tick in every wait state, so it wins
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {2{BTN_ACTIVE_LOW}};
      state <= S_LOW;
      deb_cnt <= '0;
      hold_cnt <= '0;
      hold_done <= 1'b0;
      tick_en <= 1'b0;
      db_level <= 1'b0;
      db_rise <= 1'b0;
      db_fall <= 1'b0;
      db_hold <= 1'b0;
    end else begin
      sync <= {sync[0], btn_raw};
      db_rise <= 1'b0;
      db_fall <= 1'b0;
      db_hold <= 1'b0;
      case (state)
        S_LOW: if (btn_s) begin
          state <= S_WAIT_H;
          deb_cnt <= '0;
          tick_en <= 1'b1;
        end
        S_WAIT_H: if (!btn_s) begin
          state <= S_LOW;
          tick_en <= 1'b0;
        end else if (tick) begin
          if (deb_last) begin
            state <= S_HIGH;
            db_level <= 1'b1;
            db_rise <= 1'b1;
            hold_cnt <= '0;
            hold_done <= 1'b0;
          end else deb_cnt <= deb_cnt + 1'b1;
        end
        S_HIGH: if (!btn_s) begin
          state <= S_WAIT_L;
          deb_cnt <= '0;
        end else if (tick && HOLD_TICKS != 0 && !hold_done) begin
          if (hold_last) begin
            db_hold <= 1'b1;
            hold_done <= 1'b1;
          end else hold_cnt <= hold_cnt + 1'b1;
        end
        S_WAIT_L: if (btn_s) state <= S_HIGH;
        else if (tick) begin
          if (deb_last) begin
            state <= S_LOW;
            db_level <= 1'b0;
            db_fall <= 1'b1;
            tick_en <= 1'b0;
          end else deb_cnt <= deb_cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_button_debounce_fsm.sv
// tb_button_debounce_fsm: active-high and active-low instances checked against a run-length debounce model
module tb_button_debounce_fsm;
  localparam int ST = 4;
  localparam int HT = 10;
  logic clk = 1'b0, reset = 1'b1, btn_raw = 1'b0, btn_raw_n = 1'b1, tick = 1'b0;
  logic [1:0] tick_en, db_level, db_rise, db_fall, db_hold;
  int checks = 0, failures = 0;
  int tcnt = 0, cyc_n = 0;
  int rises = 0, falls = 0, holds = 0, last_rise = 0;
  // model: pressed-level delay line, accepted level, ticks counted in the current opposing run
  logic p1 = 1'b0, p2 = 1'b0, m_level = 1'b0, m_fired = 1'b0;
  logic m_rise, m_fall, m_hold, m_en;
  int m_run = -1, m_hc = 0;

  always #5 clk = ~clk;

  button_debounce_fsm #(.STABLE_TICKS(ST), .HOLD_TICKS(HT), .BTN_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .tick(tick), .tick_en(tick_en[0]),
    .db_level(db_level[0]), .db_rise(db_rise[0]), .db_fall(db_fall[0]), .db_hold(db_hold[0]));
  button_debounce_fsm #(.STABLE_TICKS(ST), .HOLD_TICKS(HT), .BTN_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(reset), .btn_raw(btn_raw_n), .tick(tick), .tick_en(tick_en[1]),
    .db_level(db_level[1]), .db_rise(db_rise[1]), .db_fall(db_fall[1]), .db_hold(db_hold[1]));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc_n);
    end
  endtask

  task automatic model(input logic raw, input logic tk, input logic rst);
    logic bs;
    m_rise = 1'b0; m_fall = 1'b0; m_hold = 1'b0;
    if (rst) begin
      p1 = 1'b0; p2 = 1'b0; m_level = 1'b0; m_fired = 1'b0; m_run = -1; m_hc = 0;
    end else begin
      bs = p2; p2 = p1; p1 = raw;
      if (bs == m_level) begin
        m_run = -1;
        if (m_level && tk && !m_fired) begin
          m_hc++;
          if (m_hc == HT) begin m_hold = 1'b1; m_fired = 1'b1; end
        end
      end else if (m_run < 0) m_run = 0;
      else if (tk) begin
        m_run++;
        if (m_run == ST) begin
          m_level = ~m_level; m_run = -1;
          m_rise = m_level; m_fall = ~m_level;
          if (m_level) begin m_hc = 0; m_fired = 1'b0; end
        end
      end
    end
    m_en = !(m_level == 1'b0 && m_run < 0) && !rst;
  endtask

  task automatic cyc(input logic raw, input logic rst);
    logic tk;
    tk = (tcnt == 4);
    tcnt = tk ? 0 : tcnt + 1;
    btn_raw = raw; btn_raw_n = ~raw; tick = tk; reset = rst;
    @(posedge clk); #1;
    cyc_n++;
    model(raw, tk, rst);
    for (int d = 0; d < 2; d++) begin
      chk(d ? "b.tick_en" : "a.tick_en", int'(tick_en[d]), int'(m_en));
      chk(d ? "b.db_level" : "a.db_level", int'(db_level[d]), int'(m_level));
      chk(d ? "b.db_rise" : "a.db_rise", int'(db_rise[d]), int'(m_rise));
      chk(d ? "b.db_fall" : "a.db_fall", int'(db_fall[d]), int'(m_fall));
      chk(d ? "b.db_hold" : "a.db_hold", int'(db_hold[d]), int'(m_hold));
    end
    if (db_rise[0]) begin rises++; last_rise = cyc_n; end
    if (db_fall[0]) falls++;
    if (db_hold[0]) holds++;
  endtask

  task automatic run(input logic raw, input int n);
    for (int i = 0; i < n; i++) cyc(raw, 1'b0);
  endtask

  initial begin
    int t0, n;
    logic lv;
    // 1: reset then idle
    repeat (3) cyc(1'b0, 1'b1);
    chk("reset.db_level", int'(db_level[0]), 0);
    chk("reset.tick_en", int'(tick_en[0]), 0);
    rises = 0; falls = 0; holds = 0;
    run(1'b0, 100);
    chk("idle.strobes", rises + falls + holds, 0);
    // 2: clean press, latency within the tick window
    t0 = cyc_n + 1;
    run(1'b1, 30);
    chk("press.rises", rises, 1);
    chk("press.lat_ok", int'(last_rise - t0 >= 2 + (ST - 1) * 5 + 1 && last_rise - t0 <= 2 + ST * 5), 1);
    chk("press.tick_en", int'(tick_en[0]), 1);
    chk("press.level_b", int'(db_level[1]), 1);
    run(1'b0, 40);
    // 3: bounce every 7 clocks, then settle pressed
    rises = 0; falls = 0; holds = 0;
    for (int i = 0; i < 60; i++) cyc(i / 7 % 2 == 0, 1'b0);
    chk("bounce.no_rise", rises, 0);
    run(1'b1, 40);
    chk("bounce.rises", rises, 1);
    chk("bounce.falls", falls, 0);
    // 4: long press, single hold strobe
    run(1'b1, HT * 5 + 5);
    chk("hold.once", holds, 1);
    run(1'b1, 100);
    chk("hold.no_second", holds, 1);
    // 5: short glitch low while pressed
    run(1'b0, 40);
    rises = 0; falls = 0; holds = 0;
    run(1'b1, 40);
    run(1'b0, 3);
    run(1'b1, 30);
    chk("glitch.level", int'(db_level[0]), 1);
    chk("glitch.strobes", rises + falls, 1);
    run(1'b1, 60);
    chk("glitch.hold", holds, 1);
    run(1'b0, 40);
    // 6: reset lands together with the qualifying tick
    rises = 0;
    cyc(1'b1, 1'b0);
    n = 0;
    while (!(m_run == ST - 1 && tcnt == 4) && n < 100) begin cyc(1'b1, 1'b0); n++; end
    chk("rst_tick.reached", int'(n < 100), 1);
    cyc(1'b1, 1'b1);
    chk("rst_tick.no_rise", int'(db_rise[0] | db_rise[1]), 0);
    chk("rst_tick.tick_en", int'(tick_en[0] | tick_en[1]), 0);
    chk("rst_tick.rises", rises, 0);
    run(1'b0, 10);
    // random bouncing presses and releases
    lv = 1'b0;
    for (int k = 0; k < 40; k++) begin
      lv = ~lv;
      for (int b = $urandom_range(0, 4); b > 0; b--) run(b % 2 == 1 ? ~lv : lv, $urandom_range(1, 12));
      run(lv, $urandom_range(5, 90));
      if ($urandom_range(0, 19) == 0) cyc(lv, 1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
